// File: rtl/izh_pkg.sv
// Shared constants and types for the Izhikevich neuron state-update stage.
// All values are sign-magnitude: MSB is the sign, remaining bits the magnitude.
package izh_pkg;

  localparam int DEF_N = 24;
  localparam int DEF_Q = 8;

  localparam logic [DEF_N-1:0] IZH_V_PEAK  = 24'h001E00;  // +30.0
  localparam logic [DEF_N-1:0] IZH_C_RESET = 24'h804100;  // -65.0
  localparam logic [DEF_N-1:0] IZH_D_INC   = 24'h000800;  // +8.0
  localparam logic [DEF_N-1:0] IZH_V_INIT  = 24'h804100;  // -65.0
  localparam logic [DEF_N-1:0] IZH_W_INIT  = 24'h800D00;  // -13.0

  localparam logic [DEF_N-1:0] MAX_POS = {1'b0, {(DEF_N-1){1'b1}}};
  localparam logic [DEF_N-1:0] MAX_NEG = {1'b1, {(DEF_N-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_UPDATE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/izh_state_update_sm_sat_add.sv
// Combinational sign-magnitude saturating adder; a zero result is always +0.
module sm_sat_add #(
  parameter int N = 24
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o
);

  localparam int M = N - 1;

  // mag carries one extra bit so a same-sign overflow can be clamped here
  function automatic logic [N-1:0] sat_mag(input logic sgn, input logic [M:0] mag);
    logic [M-1:0] m;
    m = mag[M] ? {M{1'b1}} : mag[M-1:0];
    return (m == '0) ? '0 : {sgn, m};
  endfunction

  logic         sa, sb, sgn;
  logic [M-1:0] ma, mb;
  logic [M:0]   mag;

  assign sa = a_i[N-1];
  assign sb = b_i[N-1];
  assign ma = a_i[M-1:0];
  assign mb = b_i[M-1:0];

  always_comb begin
    mag = '0;
    sgn = 1'b0;
    if (sa == sb) begin
      mag = {1'b0, ma} + {1'b0, mb};
      sgn = sa;
    end else if (ma >= mb) begin
      mag = {1'b0, ma - mb};
      sgn = sa;
    end else begin
      mag = {1'b0, mb - ma};
      sgn = sb;
    end
    sum_o = sat_mag(sgn, mag);
  end

endmodule

// File: rtl/izh_state_update.sv
// Time-multiplexed v/w state bank for Izhikevich neurons: presents one neuron
// to the external dv/dw calculators, then integrates, spikes and writes back.
module izh_state_update
  import izh_pkg::*;
#(
  parameter int             N           = DEF_N,
  parameter int             NUM_NEURONS = 8,
  parameter int             CALC_LAT    = 2,
  parameter logic [N-1:0]   V_PEAK      = N'(IZH_V_PEAK),
  parameter logic [N-1:0]   C_RESET     = N'(IZH_C_RESET),
  parameter logic [N-1:0]   D_INC       = N'(IZH_D_INC),
  parameter logic [N-1:0]   V_INIT      = N'(IZH_V_INIT),
  parameter logic [N-1:0]   W_INIT      = N'(IZH_W_INIT),
  localparam int            IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             step_done,
  output logic [IDX_W-1:0] cur_idx,
  output logic [N-1:0]     v_out,
  output logic [N-1:0]     w_out,
  input  logic [N-1:0]     dv_in,
  input  logic [N-1:0]     dw_in,
  output logic             spike_valid,
  output logic [IDX_W-1:0] spike_idx
);

  localparam int CNT_W = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     v_q [NUM_NEURONS];
  logic [N-1:0]     w_q [NUM_NEURONS];
  logic             spike_valid_q;
  logic [IDX_W-1:0] spike_idx_q;
  logic             wr_en;

  logic [N-1:0] v_cur, w_cur, v_new, w_new, w_spk;
  logic         v_ge_peak;

  assign v_cur = v_q[idx_q];
  assign w_cur = w_q[idx_q];

  sm_sat_add #(.N(N)) u_add_v (.a_i(v_cur), .b_i(dv_in), .sum_o(v_new));
  sm_sat_add #(.N(N)) u_add_w (.a_i(w_cur), .b_i(dw_in), .sum_o(w_new));
  sm_sat_add #(.N(N)) u_add_d (.a_i(w_new), .b_i(D_INC), .sum_o(w_spk));

  // Sign-magnitude >=: differing signs decide alone, negatives compare reversed
  assign v_ge_peak = (v_new[N-1] != V_PEAK[N-1]) ? ~v_new[N-1] :
                     v_new[N-1] ? (v_new[N-2:0] <= V_PEAK[N-2:0]) :
                                  (v_new[N-2:0] >= V_PEAK[N-2:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PRESENT;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_PRESENT: begin
        if (cnt_q == CNT_W'(CALC_LAT - 1)) state_d = ST_UPDATE;
        else                               cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_UPDATE: begin
        wr_en = 1'b1;
        if (idx_q == IDX_W'(NUM_NEURONS - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_PRESENT;
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      spike_valid_q <= 1'b0;
      spike_idx_q   <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_q[i] <= V_INIT;
        w_q[i] <= W_INIT;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      spike_valid_q <= wr_en & v_ge_peak;
      if (wr_en & v_ge_peak) spike_idx_q <= idx_q;
      if (wr_en) begin
        v_q[idx_q] <= v_ge_peak ? C_RESET : v_new;
        w_q[idx_q] <= v_ge_peak ? w_spk   : w_new;
      end
    end
  end

  assign busy        = (state_q == ST_PRESENT) || (state_q == ST_UPDATE);
  assign step_done   = (state_q == ST_DONE);
  assign cur_idx     = idx_q;
  assign v_out       = v_cur;
  assign w_out       = w_cur;
  assign spike_valid = spike_valid_q;
  assign spike_idx   = spike_idx_q;

endmodule

// File: tb/tb_izh_state_update.sv
// Bench for izh_state_update: a 2-neuron/1-cycle bank driven from a vector
// table and a 4-neuron/2-cycle bank exercising reset in the middle of a step.
module tb_izh_state_update;

  localparam int NA = 2, LA = 1;
  localparam int NB = 4, LB = 2;
  localparam logic [23:0] VI = 24'h804100;
  localparam logic [23:0] WI = 24'h800D00;

  logic        clk = 1'b0;
  logic        rst_n, start, sel;
  logic [23:0] dv, dw;

  logic        a_busy, a_done, a_spk;
  logic [0:0]  a_idx, a_sidx;
  logic [23:0] a_v, a_w;
  logic        b_busy, b_done, b_spk;
  logic [1:0]  b_idx, b_sidx;
  logic [23:0] b_v, b_w;

  logic        busy_s, done_s, spk_s;
  logic [1:0]  idx_s, sidx_s;
  logic [23:0] v_s, w_s;

  izh_state_update #(.NUM_NEURONS(NA), .CALC_LAT(LA)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(a_busy), .step_done(a_done),
    .cur_idx(a_idx), .v_out(a_v), .w_out(a_w), .dv_in(dv), .dw_in(dw),
    .spike_valid(a_spk), .spike_idx(a_sidx));

  izh_state_update #(.NUM_NEURONS(NB), .CALC_LAT(LB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(b_busy), .step_done(b_done),
    .cur_idx(b_idx), .v_out(b_v), .w_out(b_w), .dv_in(dv), .dw_in(dw),
    .spike_valid(b_spk), .spike_idx(b_sidx));

  always #5 clk = ~clk;

  always_comb begin
    busy_s = sel ? b_busy : a_busy;
    done_s = sel ? b_done : a_done;
    spk_s  = sel ? b_spk  : a_spk;
    idx_s  = sel ? b_idx  : {1'b0, a_idx};
    sidx_s = sel ? b_sidx : {1'b0, a_sidx};
    v_s    = sel ? b_v    : a_v;
    w_s    = sel ? b_w    : a_w;
  end

  typedef struct {
    logic [23:0] dv, dw, ev, ew;
    bit          spk;
  } vec_t;

  typedef struct {
    logic [23:0] v, w;
  } st_t;

  st_t  st_q[$];
  int   spk_q[$];
  int   total = 0;
  int   bad   = 0;
  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic seed_init(input int num);
    st_q.delete();
    spk_q.delete();
    for (int i = 0; i < num; i++) st_q.push_back('{VI, WI});
  endtask

  task automatic run_step(input logic [23:0] dvv, dwv, ev, ew, input bit spk);
    int  num, lat, m;
    bit  seen;
    st_t e;
    num  = sel ? NB : NA;
    lat  = sel ? LB : LA;
    m    = num * (lat + 1);
    seen = 1'b0;
    if (spk) for (int i = 0; i < num; i++) spk_q.push_back(i);
    dv    = dvv;
    dw    = dwv;
    start = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= m + 4 && !seen; c++) begin
      if (c == 2) start = 1'b0;
      for (int i = 0; i < num; i++) begin
        if (c == i * (lat + 1)) begin
          if (st_q.size() > 0) e = st_q.pop_front();
          else begin
            chk("sb_empty", 0, 1);
            e = '{24'h0, 24'h0};
          end
          chk("pres_idx", idx_s, i);
          chk("pres_v", v_s, e.v);
          chk("pres_w", w_s, e.w);
          chk("pres_busy", busy_s, 1);
        end
      end
      if (spk_s) begin
        if (spk_q.size() == 0) chk("spike_unexpected", 1, 0);
        else                   chk("spike_idx", sidx_s, spk_q.pop_front());
      end
      if (done_s) begin
        seen = 1'b1;
        chk("done_latency", c, m);
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    chk("spikes_missing", spk_q.size(), 0);
    for (int i = 0; i < num; i++) st_q.push_back('{ev, ew});
    @(negedge clk);
    chk("idle_busy", busy_s, 0);
    chk("done_pulse", done_s, 0);
    chk("idle_idx", idx_s, 0);
    chk("idle_v0", v_s, ev);
    @(negedge clk);
    chk("no_queued_start", busy_s, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sel   = 1'b0;
    dv    = '0;
    dw    = '0;

    vt[0]  = '{24'h000100, 24'h000000, 24'h804000, 24'h800D00, 1'b0};
    vt[1]  = '{24'h006400, 24'h000000, 24'h804100, 24'h800500, 1'b1};
    vt[2]  = '{24'h005F00, 24'h000000, 24'h804100, 24'h000300, 1'b1};
    vt[3]  = '{24'h005EFF, 24'h000000, 24'h001DFF, 24'h000300, 1'b0};
    vt[4]  = '{24'h801DFF, 24'h801000, 24'h000000, 24'h800D00, 1'b0};
    vt[5]  = '{24'h000000, 24'h7FFFFF, 24'h000000, 24'h7FF2FF, 1'b0};
    vt[6]  = '{24'h000000, 24'h7FFFFF, 24'h000000, 24'h7FFFFF, 1'b0};
    vt[7]  = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h7FFFFF, 1'b0};
    vt[8]  = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 1'b0};
    vt[9]  = '{24'h7FFFFF, 24'h7FFFFF, 24'h000000, 24'h7FFFFF, 1'b0};
    vt[10] = '{24'h7FFFFF, 24'h000000, 24'h804100, 24'h7FFFFF, 1'b1};
    vt[11] = '{24'h000000, 24'h000000, 24'h804100, 24'h7FFFFF, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seed_init(NA);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_v", v_s, VI);
      chk("rst_w", w_s, WI);
      chk("rst_busy", busy_s, 0);
      chk("rst_idx", idx_s, 0);
      chk("rst_done", done_s, 0);
      chk("rst_spk", spk_s, 0);
      chk("rst_sidx", sidx_s, 0);
    end

    for (int k = 0; k < 12; k++)
      run_step(vt[k].dv, vt[k].dw, vt[k].ev, vt[k].ew, vt[k].spk);

    // Reset in the middle of a step on the 4-neuron bank
    sel = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dv    = 24'h000100;
    dw    = 24'h000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_before", busy_s, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy_s, 0);
    chk("abort_idx", idx_s, 0);
    chk("abort_v0", v_s, VI);
    chk("abort_w0", w_s, WI);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("abort_done", done_s, 0);
      chk("abort_spk", spk_s, 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("abort_idle", busy_s, 0);
      chk("abort_done_after", done_s, 0);
    end
    seed_init(NB);
    run_step(24'h000100, 24'h000000, 24'h804000, 24'h800D00, 1'b0);
    run_step(24'h000000, 24'h000000, 24'h804000, 24'h800D00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
